dcm_rst_seq: RTL
================

Name: dcm_rst_seq

Overview:
- Control-side companion to the DCM clock generator.
- Runs on the board reference clock (the DCM CLKIN domain, 16 MHz).
- Drives the DCM_SP RST pin with a pulse of guaranteed width, then watches LOCKED and STATUS[1] (CLKIN stopped).
- Retries with a timeout, and holds the downstream system reset until the synthesized clock has been stable for a set time. Re-sequences automatically if lock is lost.

Parameters:
RST_CYCLES, 4, width of the dcm_rst pulse in clk cycles (DCM_SP minimum is 3; must be >=3).
LOCK_TIMEOUT, 1024, clk cycles allowed in WAIT for lock before a retry.
HOLD_CYCLES, 16, consecutive locked cycles required before release.
MAX_RETRIES, 3, retries allowed before FAIL (<=15).

Ports:
clk  in  1  reference clock (DCM CLKIN domain)
rst  in  1  synchronous, active-high reset
dcm_locked  in  1  DCM LOCKED, asynchronous to clk
dcm_clkin_stopped  in  1  DCM STATUS[1], asynchronous to clk
dcm_rst  out  1  to DCM RST
sys_rst  out  1  downstream reset, active-high
ready  out  1  high in RUN only
fail  out  1  high in FAIL only
retry_cnt  out  4  retries used in the current sequence
lock_lost  out  1  sticky: lock lost at least once while in RUN

Behaviour:
- Synchronizers: dcm_locked and dcm_clkin_stopped each pass through a 2-FF synchronizer. Synchronizer flops clear to 0 on rst. Synchronized versions are locked_s and stop_s.
- Output registration: all outputs are registered and decoded from next_state, so outputs change on the same edge as the state.
- Reset (rst=1 at an edge): state=S_RST, cnt=0, retry_cnt=0, lock_lost=0, dcm_rst=1, sys_rst=1, ready=0, fail=0.
- S_RST:
  - dcm_rst=1, sys_rst=1.
  - cnt increments each cycle.
  - When cnt==RST_CYCLES-1, go to S_WAIT with cnt=0.
  - dcm_rst is therefore high for exactly RST_CYCLES cycles after rst release.
- S_WAIT:
  - dcm_rst=0, sys_rst=1, cnt increments.
  - Priority 1: stop_s=1 -> retry.
  - Priority 2: locked_s=1 -> S_HOLD with cnt=0.
  - Priority 3: cnt==LOCK_TIMEOUT-1 -> retry.
- S_HOLD:
  - sys_rst=1, cnt increments while locked_s=1.
  - locked_s=0 or stop_s=1 -> retry.
  - cnt==HOLD_CYCLES-1 with locked_s=1 -> S_RUN.
- S_RUN:
  - sys_rst=0, ready=1.
  - retry_cnt clears to 0 on entry.
  - locked_s=0 or stop_s=1 -> S_RST with cnt=0 and lock_lost=1. This does not increment retry_cnt.
- Retry:
  - If retry_cnt==MAX_RETRIES, go to S_FAIL.
  - Otherwise retry_cnt+1 and go to S_RST with cnt=0.
- S_FAIL:
  - dcm_rst=1, sys_rst=1, fail=1, ready=0.
  - Absorbing state; exits only via rst.
- Simultaneous events: rst dominates everything. In S_WAIT, stop_s dominates locked_s, and locked_s dominates timeout in the same cycle.
- Latency:
  - Let dcm_locked be first sampled high at edge N while in S_WAIT.
  - Enters S_HOLD at edge N+2.
  - sys_rst falls and ready rises at edge N+1+HOLD_CYCLES+1 (N+18 with defaults).
  - Lock loss sampled at edge M in S_RUN: sys_rst=1 and dcm_rst=1 at edge M+2.
- Counter width: cnt is wide enough for max(RST_CYCLES, LOCK_TIMEOUT, HOLD_CYCLES)-1 and never wraps.

Test Plan:
- Normal start: rst high 5 cycles then low; dcm_locked rises 100 cycles after release -> dcm_rst high exactly 4 cycles after release. With N the first edge sampling locked=1: sys_rst falls and ready=1 at edge N+18; retry_cnt=0, fail=0.
- No lock ever: dcm_locked=0 -> 4-cycle dcm_rst pulses repeat every 4+1024 cycles; retry_cnt steps 1,2,3. The 4th timeout enters FAIL: fail=1, dcm_rst=1 and sys_rst=1 held for 5000 further cycles.
- Lock loss in RUN: drop dcm_locked at edge M -> sys_rst=1, ready=0, dcm_rst=1 at M+2; lock_lost=1. Then reassert locked 50 cycles later -> returns to RUN; lock_lost stays 1; retry_cnt=0.
- HOLD glitch: 1-cycle low on dcm_locked during cycle 8 of HOLD -> S_RST, retry_cnt=1, HOLD restarts from 0. ready only after 16 fresh consecutive locked cycles.
- Priority in WAIT: dcm_clkin_stopped=1 and dcm_locked=1 asserted on the same edge -> retry taken (retry_cnt=1, new 4-cycle dcm_rst), not HOLD.
- Reset mid-operation: rst=1 for one edge in RUN (lock_lost=1) -> next cycle dcm_rst=1, sys_rst=1, ready=0, lock_lost=0, retry_cnt=0. Also rst in FAIL -> fail=0 and a new sequence starts.

Source files
------------

// File: rtl/dcm_rst_seq.sv
// dcm_rst_seq: reset/lock sequencer for a DCM_SP, running in the CLKIN domain.
// It pulses the DCM RST pin, waits for LOCKED, retries on timeout or stopped
// CLKIN, and holds the downstream reset until lock has been stable for
// HOLD_CYCLES cycles. The FSM state register is state_q (type state_e).
//
// Outputs are registered and decoded from state_d, so every output changes on
// the same clock edge as the state it belongs to.
module dcm_rst_seq #(
    parameter int RST_CYCLES   = 4,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int HOLD_CYCLES  = 16,
    parameter int MAX_RETRIES  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dcm_locked,
    input  logic       dcm_clkin_stopped,
    output logic       dcm_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic       lock_lost
);

    // One shared counter serves every timed state, so it is sized for the
    // longest interval and never wraps.
    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CNT = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_WAIT = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
        S_FAIL = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             lost_q, lost_d;
    logic             dcm_rst_q, dcm_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;

    // Two-stage synchronizers for the asynchronous DCM status pins.
    logic lock_meta_q, lock_meta_d, lock_sync_q, lock_sync_d;
    logic stop_meta_q, stop_meta_d, stop_sync_q, stop_sync_d;
    logic locked_s, stop_s;
    logic do_retry;

    assign locked_s = lock_sync_q;
    assign stop_s   = stop_sync_q;

    // Next-state, counter, retry bookkeeping and output decode.
    always_comb begin
        lock_meta_d = dcm_locked;
        lock_sync_d = lock_meta_q;
        stop_meta_d = dcm_clkin_stopped;
        stop_sync_d = stop_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        lost_d      = lost_q;
        do_retry    = 1'b0;

        case (state_q)
            S_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                // A stopped CLKIN beats a lock seen in the same cycle, and a
                // lock beats the timeout.
                if (stop_s) begin
                    do_retry = 1'b1;
                end else if (locked_s) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    do_retry = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (!locked_s || stop_s) begin
                    do_retry = 1'b1;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                // Losing lock after release re-sequences without using a retry.
                if (!locked_s || stop_s) begin
                    state_d = S_RST;
                    cnt_d   = '0;
                    lost_d  = 1'b1;
                end
            end
            S_FAIL: begin
                // Absorbing: only rst leaves this state.
            end
            default: begin
                state_d = S_RST;
                cnt_d   = '0;
            end
        endcase

        if (do_retry) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
                state_d = S_FAIL;
            end else begin
                state_d = S_RST;
                retry_d = retry_q + 4'd1;
            end
        end

        dcm_rst_d = (state_d == S_RST) || (state_d == S_FAIL);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    // State, counter, synchronizer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            lost_q      <= 1'b0;
            dcm_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            stop_meta_q <= 1'b0;
            stop_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            dcm_rst_q   <= dcm_rst_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
            lock_meta_q <= lock_meta_d;
            lock_sync_q <= lock_sync_d;
            stop_meta_q <= stop_meta_d;
            stop_sync_q <= stop_sync_d;
        end
    end

    assign dcm_rst   = dcm_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign lock_lost = lost_q;

endmodule
